inst_loader: RTL and testbench

Boot-time program loader: the writer side of the instruction-memory store port consumed by the fetch stage. It receives a byte stream from the UART receiver, packs little-endian 32-bit instruction words, and drives them into the 128-bit instruction memory one 32-bit lane per write, using the same address/data/write-enable format the core's store path uses (region `5'b11110`). When the image is complete it reports status to the host over the UART transmitter and raises `load_done` to release the core.

---
 rtl/inst_loader_pkg.sv | 25 ++
 rtl/inst_loader_word_packer.sv | 43 ++++
 rtl/inst_loader.sv | 171 +++++++++++++++++
 tb/tb_inst_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
// The optional checksum feature is selected with INST_LOADER_CKSUM_EN.
package inst_loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR   = 3'd0,
    ST_DATA  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_CKSUM = 3'd3,
    ST_ACK   = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_e;

  localparam int unsigned MAX_WORDS_DEF = 32'd65536;
  localparam logic [4:0]  IMEM_REGION   = 5'b11110;
  localparam logic [7:0]  ACK_OK_DEF    = 8'hAA;
  localparam logic [7:0]  ACK_ERR_DEF   = 8'hEE;

  // Word index k maps to lane k[1:0] of row k[15:2] inside the imem region.
  function automatic logic [29:0] imem_word_addr(input logic [15:0] k);
    return {IMEM_REGION, 9'd0, k};
  endfunction

endpackage

// File: rtl/inst_loader_word_packer.sv
// Packs a little-endian byte stream into 32-bit words; word_valid strobes
// combinationally with the 4th byte so the caller can register it directly.
module word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] sr_q, sr_d;

  // Shift register and byte counter next-state.
  always_comb begin
    word       = {in_byte, sr_q[31:8]};
    word_valid = in_valid & ~clr & (cnt_q == 2'd3);
    if (clr) begin
      cnt_d = 2'd0;
      sr_d  = 32'd0;
    end else if (in_valid) begin
      cnt_d = cnt_q + 2'd1;
      sr_d  = word;
    end else begin
      cnt_d = cnt_q;
      sr_d  = sr_q;
    end
  end

  // Packer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
      sr_q  <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Boot loader: header + words from UART into the instruction memory store port,
// then a status byte back to the host. INST_LOADER_CKSUM_EN adds an XOR checksum byte.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int unsigned MAX_WORDS = MAX_WORDS_DEF,
  parameter logic [7:0]  ACK_OK    = ACK_OK_DEF,
  parameter logic [7:0]  ACK_ERR   = ACK_ERR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        wr_ready,
  output logic        wr_en,
  output logic [29:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        load_done,
  output logic        load_err
);

  state_e      state_q, state_d;
  logic [16:0] n_q, n_d;
  logic [16:0] word_cnt_q, word_cnt_d;
  logic        wr_en_q, wr_en_d;
  logic [29:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        load_done_q, load_done_d;
  logic        load_err_q, load_err_d;

  logic        pk_en, pk_word_valid;
  logic [31:0] pk_word;
  logic        hdr_done, data_word, overflow, size_err, last_word, cksum_bad;

  assign pk_en     = (state_q == ST_HDR) || (state_q == ST_DATA);
  assign hdr_done  = (state_q == ST_HDR) & pk_word_valid;
  assign data_word = (state_q == ST_DATA) & pk_word_valid;
  assign size_err  = hdr_done & (pk_word > MAX_WORDS);
  // A word arriving while the previous one is still stalled cannot be held.
  assign overflow  = data_word & wr_en_q & ~wr_ready;
  assign last_word = (word_cnt_q == (n_q - 17'd1));

  word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (~pk_en),
    .in_valid   (rx_valid & pk_en),
    .in_byte    (rx_data),
    .word       (pk_word),
    .word_valid (pk_word_valid)
  );

`ifdef INST_LOADER_CKSUM_EN
  logic [7:0] cksum_q, cksum_d;
  assign cksum_bad = (state_q == ST_CKSUM) & rx_valid & (rx_data != cksum_q);
  localparam state_e POST_DRAIN = ST_CKSUM;
`else
  assign cksum_bad = 1'b0;
  localparam state_e POST_DRAIN = ST_ACK;
`endif

  // State register and all datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HDR;
      n_q         <= 17'd0;
      word_cnt_q  <= 17'd0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 30'd0;
      wr_data_q   <= 32'd0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'd0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
`ifdef INST_LOADER_CKSUM_EN
      cksum_q     <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      word_cnt_q  <= word_cnt_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
`ifdef INST_LOADER_CKSUM_EN
      cksum_q     <= cksum_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HDR: begin
        if (!hdr_done)                 state_d = ST_HDR;
        else if (pk_word == 32'd0)     state_d = POST_DRAIN;
        else if (size_err)             state_d = ST_ERR;
        else                           state_d = ST_DATA;
      end
      ST_DATA: begin
        if (!data_word)                state_d = ST_DATA;
        else if (overflow)             state_d = ST_ERR;
        else if (last_word)            state_d = ST_DRAIN;
        else                           state_d = ST_DATA;
      end
      ST_DRAIN: begin
        if (!wr_en_q || wr_ready)      state_d = POST_DRAIN;
        else                           state_d = ST_DRAIN;
      end
`ifdef INST_LOADER_CKSUM_EN
      ST_CKSUM: begin
        if (rx_valid)                  state_d = ST_ACK;
        else                           state_d = ST_CKSUM;
      end
`endif
      ST_ACK, ST_ERR: begin
        if (tx_valid_q && tx_ready)    state_d = ST_DONE;
        else                           state_d = state_q;
      end
      ST_DONE:                         state_d = ST_DONE;
      default:                         state_d = ST_HDR;
    endcase
  end

  // Output and datapath next values, keyed off the next state.
  always_comb begin
    n_d         = hdr_done ? pk_word[16:0] : n_q;
    load_err_d  = load_err_q | overflow | size_err | cksum_bad;
    tx_valid_d  = (state_d == ST_ACK) || (state_d == ST_ERR);
    tx_data_d   = tx_valid_d ? (load_err_d ? ACK_ERR : ACK_OK) : 8'd0;
    load_done_d = (state_d == ST_DONE);
    word_cnt_d  = word_cnt_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    if (state_d == ST_ERR) begin
      wr_en_d = 1'b0;
    end else if (data_word) begin
      wr_en_d    = 1'b1;
      wr_addr_d  = imem_word_addr(word_cnt_q[15:0]);
      wr_data_d  = pk_word;
      word_cnt_d = word_cnt_q + 17'd1;
    end else if (wr_en_q && wr_ready) begin
      wr_en_d = 1'b0;
    end else begin
      wr_en_d = wr_en_q;
    end
`ifdef INST_LOADER_CKSUM_EN
    if ((state_q == ST_DATA) && rx_valid) cksum_d = cksum_q ^ rx_data;
    else                                  cksum_d = cksum_q;
`endif
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: framing, backpressure, overflow, size error,
// status handshake; checksum cases when INST_LOADER_CKSUM_EN is defined.
module tb_inst_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        wr_ready;
  logic        wr_en;
  logic [29:0] wr_addr;
  logic [31:0] wr_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        load_done;
  logic        load_err;

  int          n_checks = 0;
  int          n_pass   = 0;

  logic [29:0] wa [0:31];
  logic [31:0] wd [0:31];
  int          nw     = 0;
  int          err_wr = 0;
  logic [7:0]  last_tx = 8'd0;

  inst_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .wr_ready  (wr_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  // Log accepted writes, status handshakes and any write requested after an error.
  always @(posedge clk) begin
    if (rst_n) begin
      if (wr_en && wr_ready && nw < 32) begin
        wa[nw] = wr_addr;
        wd[nw] = wr_data;
        nw = nw + 1;
      end
      if (tx_valid && tx_ready) last_tx = tx_data;
      if (wr_en && load_err) err_wr = err_wr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    repeat (2) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'd0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  function automatic logic [7:0] bx(input logic [31:0] w);
    return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endfunction

  task automatic do_reset;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    wr_ready = 1'b1;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && !load_done; i++) @(negedge clk);
    chk(tag, {31'd0, load_done}, 32'd1);
  endtask

  int   base;
  logic ok;

  initial begin
    do_reset;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_flags", {28'd0, wr_en, tx_valid, load_done, load_err}, 32'd0);
    chk("rst_wr_addr", {2'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);

    // N=3, no backpressure.
    do_reset;
    base = nw;
    send_word(32'd3);
    send_word(32'h11223344);
    chk("t1_lat_wr_en", {31'd0, wr_en}, 32'd1);
    chk("t1_lat_addr", {2'd0, wr_addr}, 32'h3C000000);
    chk("t1_lat_data", wr_data, 32'h11223344);
    send_word(32'h55667788);
    send_word(32'h99AABBCC);
`ifdef INST_LOADER_CKSUM_EN
    send_byte(bx(32'h11223344) ^ bx(32'h55667788) ^ bx(32'h99AABBCC));
`endif
    wait_done("t1_done", 200);
    chk("t1_nwr", nw - base, 32'd3);
    chk("t1_a1", {2'd0, wa[base+1]}, 32'h3C000001);
    chk("t1_d1", wd[base+1], 32'h55667788);
    chk("t1_a2", {2'd0, wa[base+2]}, 32'h3C000002);
    chk("t1_d2", wd[base+2], 32'h99AABBCC);
    chk("t1_status", {24'd0, last_tx}, 32'hAA);
    chk("t1_err", {31'd0, load_err}, 32'd0);

    // N=2, word 0 stalled 40 cycles, word 1 sent after release.
    do_reset;
    base = nw;
    wr_ready = 1'b0;
    send_word(32'd2);
    send_word(32'hDEADBEEF);
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!(wr_en === 1'b1 && wr_addr === 30'h3C000000 && wr_data === 32'hDEADBEEF && load_err === 1'b0))
        ok = 1'b0;
      @(negedge clk);
    end
    chk("t2_stable", {31'd0, ok}, 32'd1);
    chk("t2_nwr_stall", nw - base, 32'd0);
    wr_ready = 1'b1;
    send_word(32'hCAFEF00D);
`ifdef INST_LOADER_CKSUM_EN
    send_byte(bx(32'hDEADBEEF) ^ bx(32'hCAFEF00D));
`endif
    wait_done("t2_done", 200);
    chk("t2_nwr", nw - base, 32'd2);
    chk("t2_a0", {2'd0, wa[base]}, 32'h3C000000);
    chk("t2_d0", wd[base], 32'hDEADBEEF);
    chk("t2_a1", {2'd0, wa[base+1]}, 32'h3C000001);
    chk("t2_d1", wd[base+1], 32'hCAFEF00D);
    chk("t2_status", {24'd0, last_tx}, 32'hAA);

    // N=3 with wr_ready held low: the second completed word overflows.
    do_reset;
    base = nw;
    wr_ready = 1'b0;
    send_word(32'd3);
    send_word(32'h11223344);
    chk("t3_no_err_w0", {31'd0, load_err}, 32'd0);
    send_word(32'h55667788);
    chk("t3_err_set", {31'd0, load_err}, 32'd1);
    chk("t3_wr_en_off", {31'd0, wr_en}, 32'd0);
    send_word(32'h99AABBCC);
    wait_done("t3_done", 200);
    chk("t3_no_wr_after_err", err_wr, 32'd0);
    chk("t3_nwr", nw - base, 32'd0);
    chk("t3_status", {24'd0, last_tx}, 32'hEE);

    // Oversized header.
    do_reset;
    base = nw;
    send_word(32'h00010001);
    chk("t4_err", {31'd0, load_err}, 32'd1);
    chk("t4_tx", {23'd0, tx_valid, tx_data}, 32'h1EE);
    wait_done("t4_done", 50);
    chk("t4_nwr", nw - base, 32'd0);
    chk("t4_status", {24'd0, last_tx}, 32'hEE);

    // N=5, row wrap, status withheld for 10 cycles.
    do_reset;
    base = nw;
    tx_ready = 1'b0;
    send_word(32'd5);
    for (int i = 0; i < 5; i++) send_word(32'hA0000000 + i);
`ifdef INST_LOADER_CKSUM_EN
    send_byte(8'hA0 ^ 8'hA0 ^ 8'hA0 ^ 8'hA0 ^ 8'hA0 ^ 8'h00 ^ 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04);
`endif
    for (int i = 0; i < 50 && !tx_valid; i++) @(negedge clk);
    chk("t5_tx_valid", {31'd0, tx_valid}, 32'd1);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!(tx_valid === 1'b1 && tx_data === 8'hAA && load_done === 1'b0)) ok = 1'b0;
      @(negedge clk);
    end
    chk("t5_tx_hold", {31'd0, ok}, 32'd1);
    tx_ready = 1'b1;
    @(negedge clk);
    chk("t5_done_next", {31'd0, load_done}, 32'd1);
    tx_ready = 1'b0;
    chk("t5_nwr", nw - base, 32'd5);
    chk("t5_a4", {2'd0, wa[base+4]}, 32'h3C000004);
    chk("t5_d4", wd[base+4], 32'hA0000004);
    chk("t5_status", {24'd0, last_tx}, 32'hAA);

`ifdef INST_LOADER_CKSUM_EN
    // Checksum correct, then wrong.
    do_reset;
    base = nw;
    send_word(32'd1);
    send_word(32'h01020304);
    send_byte(8'h04);
    wait_done("c1_done", 50);
    chk("c1_status", {24'd0, last_tx}, 32'hAA);
    chk("c1_nwr", nw - base, 32'd1);
    do_reset;
    base = nw;
    send_word(32'd1);
    send_word(32'h01020304);
    send_byte(8'h05);
    wait_done("c2_done", 50);
    chk("c2_status", {24'd0, last_tx}, 32'hEE);
    chk("c2_nwr", nw - base, 32'd1);
    chk("c2_data", wd[base], 32'h01020304);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
